// File: rtl/vga_pkg.sv
// ============================================================================
// Module   : vga_pkg
// Purpose  : 640x480@60 timing constants, totals, address width, sync polarity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int c_H_ACTIVE = 640;
    localparam int c_H_FP     = 16;
    localparam int c_H_SYNC   = 96;
    localparam int c_H_BP     = 48;
    localparam int c_V_ACTIVE = 480;
    localparam int c_V_FP     = 10;
    localparam int c_V_SYNC   = 2;
    localparam int c_V_BP     = 33;

    localparam int c_H_TOTAL  = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;
    localparam int c_V_TOTAL  = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;
    localparam int c_ADDR_W   = 19;

    // Both syncs are asserted low.
    localparam logic c_SYNC_ACTIVE = 1'b0;

endpackage

`default_nettype wire

// File: rtl/vga_axis_cnt.sv
// ============================================================================
// Module   : vga_axis_cnt
// Purpose  : Free-running 0..MAX counter with enable and same-cycle wrap flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_cnt #(
    parameter int MAX = 799,
    parameter int W   = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] c_MAX = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap_o = en_i && (cnt_q == c_MAX);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_scan_ctrl.sv
// ============================================================================
// Module   : vga_scan_ctrl
// Purpose  : VGA raster scan: frame-buffer addressing, syncs, 2-stage output.
//            Optional test pattern enabled by macro VGA_SCAN_TESTPAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE,
    parameter int H_FP     = c_H_FP,
    parameter int H_SYNC   = c_H_SYNC,
    parameter int H_BP     = c_H_BP,
    parameter int V_ACTIVE = c_V_ACTIVE,
    parameter int V_FP     = c_V_FP,
    parameter int V_SYNC   = c_V_SYNC,
    parameter int V_BP     = c_V_BP,
    parameter int ADDR_W   = c_ADDR_W
) (
    input  logic              PIXELCLK,
    input  logic              RSTn,
    output logic [ADDR_W-1:0] o_raddr,
    input  logic [7:0]        i_rdata,
    input  logic              i_tp_en,
    output logic              o_w_en,
    output logic [7:0]        o_data,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0]     c_HA        = HW'(H_ACTIVE);
    localparam logic [HW-1:0]     c_HS_START  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]     c_HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]     c_VA        = VW'(V_ACTIVE);
    localparam logic [VW-1:0]     c_VS_START  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]     c_VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [ADDR_W-1:0] c_ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    logic [HW-1:0]     w_h_cnt;
    logic              w_h_wrap;
    logic [VW-1:0]     w_v_cnt;
    logic              w_v_wrap_unused;
    logic              w_active0;
    logic              w_hsync0;
    logic              w_vsync0;
    logic              w_fs0;
    logic [7:0]        w_pixel_src;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W-1:0] raddr_d;
    logic              active_d1_q;
    logic              hsync_d1_q;
    logic              vsync_d1_q;
    logic              fs_d1_q;

    vga_axis_cnt #(.MAX(H_TOTAL - 1), .W(HW)) u_h_cnt (
        .clk_i  (PIXELCLK),
        .rst_ni (RSTn),
        .en_i   (1'b1),
        .cnt_o  (w_h_cnt),
        .wrap_o (w_h_wrap)
    );

    vga_axis_cnt #(.MAX(V_TOTAL - 1), .W(VW)) u_v_cnt (
        .clk_i  (PIXELCLK),
        .rst_ni (RSTn),
        .en_i   (w_h_wrap),
        .cnt_o  (w_v_cnt),
        .wrap_o (w_v_wrap_unused)
    );

    always_comb begin
        w_active0 = (w_h_cnt < c_HA) && (w_v_cnt < c_VA);
        w_hsync0  = ((w_h_cnt >= c_HS_START) && (w_h_cnt < c_HS_END)) ? c_SYNC_ACTIVE : ~c_SYNC_ACTIVE;
        w_vsync0  = ((w_v_cnt >= c_VS_START) && (w_v_cnt < c_VS_END)) ? c_SYNC_ACTIVE : ~c_SYNC_ACTIVE;
        w_fs0     = (w_h_cnt == '0) && (w_v_cnt == '0);
    end

    // Address tracks the active raster only, so it holds through blanking.
    always_comb begin
        raddr_d = raddr_q;
        if (w_active0) begin
            raddr_d = (raddr_q == c_ADDR_LAST) ? '0 : raddr_q + ADDR_W'(1);
        end
    end

    assign o_raddr = raddr_q;

`ifdef VGA_SCAN_TESTPAT_EN
    logic [7:0] x_d1_q;
    logic [7:0] y_d1_q;

    always_ff @(posedge PIXELCLK or negedge RSTn) begin
        if (!RSTn) begin
            x_d1_q <= '0;
            y_d1_q <= '0;
        end else begin
            x_d1_q <= 8'(w_h_cnt);
            y_d1_q <= 8'(w_v_cnt);
        end
    end

    assign w_pixel_src = i_tp_en ? (x_d1_q ^ y_d1_q) : i_rdata;
`else
    logic w_tp_en_unused;

    assign w_tp_en_unused = i_tp_en;
    assign w_pixel_src    = i_rdata;
`endif

    // Stage 1 lines up with the RAM read; stage 2 is the output register.
    always_ff @(posedge PIXELCLK or negedge RSTn) begin
        if (!RSTn) begin
            raddr_q       <= '0;
            active_d1_q   <= 1'b0;
            hsync_d1_q    <= ~c_SYNC_ACTIVE;
            vsync_d1_q    <= ~c_SYNC_ACTIVE;
            fs_d1_q       <= 1'b0;
            o_w_en        <= 1'b1;
            o_data        <= 8'h00;
            o_hsync       <= ~c_SYNC_ACTIVE;
            o_vsync       <= ~c_SYNC_ACTIVE;
            o_frame_start <= 1'b0;
        end else begin
            raddr_q       <= raddr_d;
            active_d1_q   <= w_active0;
            hsync_d1_q    <= w_hsync0;
            vsync_d1_q    <= w_vsync0;
            fs_d1_q       <= w_fs0;
            o_w_en        <= ~active_d1_q;
            o_data        <= active_d1_q ? w_pixel_src : 8'h00;
            o_hsync       <= hsync_d1_q;
            o_vsync       <= vsync_d1_q;
            o_frame_start <= fs_d1_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
// ============================================================================
// Module   : tb_vga_scan_ctrl
// Purpose  : Scoreboard bench for vga_scan_ctrl on a reduced raster geometry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_scan_ctrl;

    localparam int HA  = 16;
    localparam int HF  = 2;
    localparam int HSY = 4;
    localparam int HB  = 3;
    localparam int VA  = 8;
    localparam int VF  = 2;
    localparam int VSY = 2;
    localparam int VB  = 3;
    localparam int AW  = 19;
    localparam int HT  = HA + HF + HSY + HB;
    localparam int VT  = VA + VF + VSY + VB;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic       w_en;
        logic [7:0] data;
        logic       hs;
        logic       vs;
        logic       fs;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rstn  = 1'b1;
    logic [7:0]    rdata = 8'h00;
    logic          tp_en = 1'b0;
    logic [AW-1:0] o_raddr;
    logic          o_w_en;
    logic [7:0]    o_data;
    logic          o_hsync;
    logic          o_vsync;
    logic          o_frame_start;

    int            checks = 0;
    int            errors = 0;
    exp_t          q[$];
    int            mh = 0;
    int            mv = 0;
    int            maddr = 0;
    logic          ram_const = 1'b0;
    logic [7:0]    const_val = 8'h00;
    logic [AW-1:0] addr_prev;

    vga_scan_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .ADDR_W(AW)
    ) dut (
        .PIXELCLK      (clk),
        .RSTn          (rstn),
        .o_raddr       (o_raddr),
        .i_rdata       (rdata),
        .i_tp_en       (tp_en),
        .o_w_en        (o_w_en),
        .o_data        (o_data),
        .o_hsync       (o_hsync),
        .o_vsync       (o_vsync),
        .o_frame_start (o_frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ramf(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] model_pix();
        if (!((mh < HA) && (mv < VA))) return 8'h00;
`ifdef VGA_SCAN_TESTPAT_EN
        if (tp_en) return 8'(mh) ^ 8'(mv);
`endif
        return ram_const ? const_val : ramf(AW'(maddr));
    endfunction

    // Called at a falling edge; leaves at the next falling edge.
    task automatic step();
        exp_t e;
        exp_t g;
        checks++;
        if (o_raddr !== AW'(maddr)) begin
            errors++;
            $display("FAIL raddr h=%0d v=%0d got %0d exp %0d", mh, mv, o_raddr, maddr);
        end
        e.w_en = !((mh < HA) && (mv < VA));
        e.data = model_pix();
        e.hs   = !((mh >= HA + HF) && (mh < HA + HF + HSY));
        e.vs   = !((mv >= VA + VF) && (mv < VA + VF + VSY));
        e.fs   = (mh == 0) && (mv == 0);
        q.push_back(e);
        addr_prev = o_raddr;
        @(posedge clk);
        #1;
        rdata = ram_const ? const_val : ramf(addr_prev);
        if (!e.w_en) maddr = (maddr == HA * VA - 1) ? 0 : maddr + 1;
        mh++;
        if (mh == HT) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end
        @(negedge clk);
        g = q.pop_front();
        checks++;
        if ({o_w_en, o_data, o_hsync, o_vsync, o_frame_start} !== g) begin
            errors++;
            $display("FAIL outputs got wen=%b data=%h hs=%b vs=%b fs=%b exp wen=%b data=%h hs=%b vs=%b fs=%b",
                     o_w_en, o_data, o_hsync, o_vsync, o_frame_start, g.w_en, g.data, g.hs, g.vs, g.fs);
        end
    endtask

    // Asserts reset mid-cycle, checks the asynchronous effect, then releases
    // just after a rising edge (that edge counts as edge 1 after release).
    task automatic do_reset();
        exp_t r;
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({o_w_en, o_data, o_hsync, o_vsync, o_frame_start, o_raddr} !==
            {1'b1, 8'h00, 1'b1, 1'b1, 1'b0, {AW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_values got wen=%b data=%h hs=%b vs=%b fs=%b raddr=%0d exp 1,00,1,1,0,0",
                     o_w_en, o_data, o_hsync, o_vsync, o_frame_start, o_raddr);
        end
        mh = 0;
        mv = 0;
        maddr = 0;
        q.delete();
        r.w_en = 1'b1; r.data = 8'h00; r.hs = 1'b1; r.vs = 1'b1; r.fs = 1'b0;
        q.push_back(r);
        rdata = ram_const ? const_val : ramf('0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic step_until(input int h, input int v, input string name);
        int n = 0;
        while (!(mh == h && mv == v) && n < FRAME + 4) begin
            step();
            n++;
        end
        checks++;
        if (!(mh == h && mv == v)) begin
            errors++;
            $display("FAIL %s position not reached got h=%0d v=%0d exp h=%0d v=%0d", name, mh, mv, h, v);
        end
    endtask

    task automatic test_reset();
        int edges = 1;
        ram_const = 1'b1;
        const_val = 8'hA5;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step();
            edges++;
            if (o_frame_start === 1'b1) break;
        end
        checks++;
        if (edges != 3 || o_w_en !== 1'b0 || o_data !== 8'hA5) begin
            errors++;
            $display("FAIL first_pixel got edge=%0d wen=%b data=%h exp edge=3 wen=0 data=a5", edges, o_w_en, o_data);
        end
        step();
        checks++;
        if (o_frame_start !== 1'b0) begin
            errors++;
            $display("FAIL fs_single got %b exp 0", o_frame_start);
        end
        for (int k = 0; k < HT; k++) step();
    endtask

    task automatic test_free_run();
        int   cyc = 0, hs_run = 0, vs_run = 0, wen_run = 0;
        int   line_start = -1, last_fs = -1, fs_count = 0;
        logic p_wen = 1'b1, p_hs = 1'b1;
        ram_const = 1'b0;
        tp_en = 1'b0;
        do_reset();
        for (int i = 0; i < 2 * FRAME + 3 * HT; i++) begin
            step();
            cyc++;
            if (p_wen && !o_w_en) line_start = cyc;
            if (p_hs && !o_hsync && line_start >= 0) begin
                checks++;
                if (cyc - line_start != HA + HF) begin
                    errors++;
                    $display("FAIL hsync_offset got %0d exp %0d", cyc - line_start, HA + HF);
                end
                line_start = -1;
            end
            if (!o_hsync) hs_run++;
            else if (hs_run != 0) begin
                checks++;
                if (hs_run != HSY) begin
                    errors++;
                    $display("FAIL hsync_width got %0d exp %0d", hs_run, HSY);
                end
                hs_run = 0;
            end
            if (!o_w_en) wen_run++;
            else if (wen_run != 0) begin
                checks++;
                if (wen_run != HA) begin
                    errors++;
                    $display("FAIL active_width got %0d exp %0d", wen_run, HA);
                end
                wen_run = 0;
            end
            if (!o_vsync) vs_run++;
            else if (vs_run != 0) begin
                checks++;
                if (vs_run != VSY * HT) begin
                    errors++;
                    $display("FAIL vsync_width got %0d exp %0d", vs_run, VSY * HT);
                end
                vs_run = 0;
            end
            if (o_frame_start) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc - last_fs != FRAME) begin
                        errors++;
                        $display("FAIL frame_period got %0d exp %0d", cyc - last_fs, FRAME);
                    end
                end
                last_fs = cyc;
                fs_count++;
            end
            p_wen = o_w_en;
            p_hs  = o_hsync;
        end
        checks++;
        if (fs_count != 3) begin
            errors++;
            $display("FAIL frame_count got %0d exp 3", fs_count);
        end
    endtask

    task automatic test_address();
        do_reset();
        step_until(HA - 1, 0, "addr_line0_end");
        checks++;
        if (o_raddr !== AW'(HA - 1)) begin
            errors++;
            $display("FAIL addr_line0_end got %0d exp %0d", o_raddr, HA - 1);
        end
        step_until(0, 1, "addr_line1_start");
        checks++;
        if (o_raddr !== AW'(HA)) begin
            errors++;
            $display("FAIL addr_line1_start got %0d exp %0d", o_raddr, HA);
        end
        step_until(HA - 1, VA - 1, "addr_last");
        checks++;
        if (o_raddr !== AW'(HA * VA - 1)) begin
            errors++;
            $display("FAIL addr_last got %0d exp %0d", o_raddr, HA * VA - 1);
        end
        step();
        checks++;
        if (o_raddr !== '0) begin
            errors++;
            $display("FAIL addr_wrap got %0d exp 0", o_raddr);
        end
        step_until(0, 0, "addr_frame2");
    endtask

    task automatic test_midframe_reset();
        do_reset();
        step_until(HA + HF + 2, 5, "mid_pos");
        checks++;
        if (o_hsync !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_hsync got %b exp 0", o_hsync);
        end
        do_reset();
        for (int k = 0; k < 2 * HT; k++) step();
    endtask

    task automatic test_pattern();
        logic [7:0] want;
        tp_en = 1'b1;
        ram_const = 1'b0;
`ifdef VGA_SCAN_TESTPAT_EN
        want = 8'h06;
`else
        want = ramf(AW'(5 * HA + 3));
`endif
        do_reset();
        step_until(3, 5, "tp_pos");
        step();
        step();
        checks++;
        if (o_data !== want || o_w_en !== 1'b0) begin
            errors++;
            $display("FAIL tp_pixel got data=%h wen=%b exp data=%h wen=0", o_data, o_w_en, want);
        end
        step_until(HA, 5, "tp_blank");
        step();
        step();
        checks++;
        if (o_data !== 8'h00 || o_w_en !== 1'b1) begin
            errors++;
            $display("FAIL tp_blank got data=%h wen=%b exp data=00 wen=1", o_data, o_w_en);
        end
        tp_en = 1'b0;
    endtask

    initial begin
        #1 rstn = 1'b0;
        @(negedge clk);
        test_reset();
        test_free_run();
        test_address();
        test_midframe_reset();
        test_pattern();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
